// File: rtl/matmul_weight_bank.sv
// Signed weight store for a per-class matrix-multiply engine: one write and one
// read port, with a self-running init sequence that loads a fixed half-plane pattern.
module matmul_weight_bank #(
    parameter int WIDTH_P        = 8,
    parameter int HEIGHT_P       = 8,
    parameter int NUM_CLASSES_P  = 4,
    parameter int WEIGHT_WIDTH_P = 8,
    parameter int DEFAULT_MAG_P  = 2,
    localparam int PIX   = WIDTH_P * HEIGHT_P,
    localparam int DEPTH = NUM_CLASSES_P * PIX,
    localparam int CW    = (NUM_CLASSES_P > 1) ? $clog2(NUM_CLASSES_P) : 1,
    localparam int AW    = $clog2(PIX)
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      init_i,
    output logic                      busy_o,
    input  logic                      wr_valid_i,
    output logic                      wr_ready_o,
    input  logic [CW-1:0]             wr_class_i,
    input  logic [AW-1:0]             wr_addr_i,
    input  logic [WEIGHT_WIDTH_P-1:0] wr_data_i,
    input  logic                      rd_valid_i,
    input  logic [CW-1:0]             rd_class_i,
    input  logic [AW-1:0]             rd_addr_i,
    output logic                      rd_valid_o,
    output logic [WEIGHT_WIDTH_P-1:0] rd_data_o,
    output logic                      rd_err_o
);

    localparam int IW = $clog2(DEPTH);
    localparam int XW = $clog2(WIDTH_P);
    localparam logic [WEIGHT_WIDTH_P-1:0] MAG_POS = WEIGHT_WIDTH_P'(DEFAULT_MAG_P);
    localparam logic [WEIGHT_WIDTH_P-1:0] MAG_NEG = WEIGHT_WIDTH_P'(-DEFAULT_MAG_P);

    typedef enum logic {ST_INIT, ST_READY} state_t;

    state_t  state, state_d;
    logic [IW-1:0] cnt, cnt_d;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state <= ST_INIT;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_d = state;
        cnt_d   = '0;
        case (state)
            ST_INIT: begin
                if (cnt == IW'(DEPTH - 1)) state_d = ST_READY;
                else                       cnt_d   = cnt + 1'b1;
            end
            ST_READY: begin
                if (init_i) state_d = ST_INIT;
            end
            default: state_d = ST_INIT;
        endcase
    end

    assign busy_o     = (state == ST_INIT);
    assign wr_ready_o = (state == ST_READY);

    // Init pattern: the MSB of y / x within the pixel address selects the half-plane.
    logic [31:0]               init_cls;
    logic                      y_hi, x_hi;
    logic [WEIGHT_WIDTH_P-1:0] init_data;

    always_comb begin
        init_cls  = 32'(cnt >> AW);
        y_hi      = cnt[AW-1];
        x_hi      = cnt[XW-1];
        init_data = '0;
        case (init_cls)
            32'd0:   init_data = y_hi ? MAG_NEG : MAG_POS;
            32'd1:   init_data = y_hi ? MAG_POS : MAG_NEG;
            32'd2:   init_data = x_hi ? MAG_NEG : MAG_POS;
            32'd3:   init_data = x_hi ? MAG_POS : MAG_NEG;
            default: init_data = '0;
        endcase
    end

    logic                      wr_in_range, rd_in_range;
    logic [IW-1:0]             wr_idx, rd_idx;
    logic                      mem_we;
    logic [IW-1:0]             mem_waddr;
    logic [WEIGHT_WIDTH_P-1:0] mem_wdata;

    // Class-major layout with power-of-2 PIX makes the index a plain concatenation.
    assign wr_in_range = 32'(wr_class_i) < NUM_CLASSES_P;
    assign rd_in_range = 32'(rd_class_i) < NUM_CLASSES_P;
    assign wr_idx      = IW'({wr_class_i, wr_addr_i});
    assign rd_idx      = IW'({rd_class_i, rd_addr_i});

    always_comb begin
        if (busy_o) begin
            mem_we    = 1'b1;
            mem_waddr = cnt;
            mem_wdata = init_data;
        end else begin
            mem_we    = wr_valid_i & wr_in_range;
            mem_waddr = wr_idx;
            mem_wdata = wr_data_i;
        end
    end

    logic [WEIGHT_WIDTH_P-1:0] mem [DEPTH];

    // NOTE: the array has no reset; its contents are rebuilt by the init sequence,
    // which keeps it mappable onto block RAM.
    always_ff @(posedge clk_i) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    logic rd_acc;
    assign rd_acc = rd_valid_i & wr_ready_o;

    // Reading mem here sees the pre-edge contents, so a same-entry write returns old data.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rd_valid_o <= 1'b0;
            rd_data_o  <= '0;
            rd_err_o   <= 1'b0;
        end else begin
            rd_valid_o <= rd_acc;
            rd_err_o   <= rd_acc & ~rd_in_range;
            if (rd_acc) rd_data_o <= rd_in_range ? mem[rd_idx] : '0;
        end
    end

endmodule

// File: tb/tb_matmul_weight_bank.sv
// Directed bench for matmul_weight_bank: default instance plus a 5-class instance
// for out-of-range class handling.
module tb_matmul_weight_bank;

    logic clk = 1'b0;
    logic reset_i = 1'b1;
    always #5 clk = ~clk;

    // default instance (4 classes)
    logic       init, busy, wr_valid, wr_ready, rd_req, rd_valid, rd_err;
    logic [1:0] wr_class, rd_class;
    logic [5:0] wr_addr, rd_addr;
    logic [7:0] wr_data, rd_data;

    // 5-class instance
    logic       init5, busy5, wr_valid5, wr_ready5, rd_req5, rd_valid5, rd_err5;
    logic [2:0] wr_class5, rd_class5;
    logic [5:0] wr_addr5, rd_addr5;
    logic [7:0] wr_data5, rd_data5;

    matmul_weight_bank dut (
        .clk_i(clk), .reset_i(reset_i), .init_i(init), .busy_o(busy),
        .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_class_i(wr_class),
        .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .rd_valid_i(rd_req), .rd_class_i(rd_class), .rd_addr_i(rd_addr),
        .rd_valid_o(rd_valid), .rd_data_o(rd_data), .rd_err_o(rd_err)
    );

    matmul_weight_bank #(.NUM_CLASSES_P(5)) dut5 (
        .clk_i(clk), .reset_i(reset_i), .init_i(init5), .busy_o(busy5),
        .wr_valid_i(wr_valid5), .wr_ready_o(wr_ready5), .wr_class_i(wr_class5),
        .wr_addr_i(wr_addr5), .wr_data_i(wr_data5),
        .rd_valid_i(rd_req5), .rd_class_i(rd_class5), .rd_addr_i(rd_addr5),
        .rd_valid_o(rd_valid5), .rd_data_o(rd_data5), .rd_err_o(rd_err5)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0] cls;
        logic [5:0] addr;
        int         exp;
    } rd_vec_t;

    rd_vec_t tbl [8];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [1:0] cls, input logic [5:0] addr, input int exp,
                           input string name);
        rd_req   = 1'b1;
        rd_class = cls;
        rd_addr  = addr;
        tick();
        check({name, " valid"}, int'(rd_valid), 1);
        check({name, " data"}, int'($signed(rd_data)), exp);
        check({name, " err"}, int'(rd_err), 0);
        rd_req = 1'b0;
    endtask

    // Counts cycles until busy drops; also records whether rd_valid showed up meanwhile.
    task automatic count_busy(output int n, output int vseen);
        n = 0;
        vseen = 0;
        while (busy && n < 2000) begin
            tick();
            n++;
            if (rd_valid && busy) vseen++;
        end
    endtask

    initial begin
        int n, vseen;

        init = 0; wr_valid = 0; wr_class = 0; wr_addr = 0; wr_data = 0;
        rd_req = 0; rd_class = 0; rd_addr = 0;
        init5 = 0; wr_valid5 = 0; wr_class5 = 0; wr_addr5 = 0; wr_data5 = 0;
        rd_req5 = 0; rd_class5 = 0; rd_addr5 = 0;

        tbl[0] = '{2'd0, 6'd0,  2};
        tbl[1] = '{2'd0, 6'd63, -2};
        tbl[2] = '{2'd3, 6'd7,  2};
        tbl[3] = '{2'd2, 6'd7,  -2};
        tbl[4] = '{2'd1, 6'd0,  -2};
        tbl[5] = '{2'd1, 6'd32, 2};
        tbl[6] = '{2'd2, 6'd3,  2};
        tbl[7] = '{2'd3, 6'd56, -2};

        repeat (3) tick();
        check("reset busy", int'(busy), 1);
        check("reset wr_ready", int'(wr_ready), 0);
        check("reset rd_valid", int'(rd_valid), 0);
        check("reset rd_data", int'(rd_data), 0);
        check("reset rd_err", int'(rd_err), 0);

        // init after reset release, with reads requested throughout
        reset_i = 1'b0;
        rd_req = 1'b1;
        count_busy(n, vseen);
        rd_req = 1'b0;
        check("init cycles", n, 256);
        check("reads during init", vseen, 0);
        check("wr_ready after init", int'(wr_ready), 1);

        foreach (tbl[i])
            do_read(tbl[i].cls, tbl[i].addr, tbl[i].exp, $sformatf("default[%0d]", i));

        // hold of rd_data while idle
        tick();
        check("idle rd_valid", int'(rd_valid), 0);
        check("idle rd_data hold", int'($signed(rd_data)), -2);

        // write then read
        wr_valid = 1; wr_class = 2'd1; wr_addr = 6'd10; wr_data = 8'hFB;
        check("wr_ready", int'(wr_ready), 1);
        tick();
        wr_valid = 0;
        do_read(2'd1, 6'd10, -5, "write -5");

        // same-cycle read and write of one entry returns old data
        wr_valid = 1; wr_data = 8'd7;
        rd_req = 1; rd_class = 2'd1; rd_addr = 6'd10;
        tick();
        wr_valid = 0; rd_req = 0;
        check("rw same entry old", int'($signed(rd_data)), -5);
        do_read(2'd1, 6'd10, 7, "after rw");

        // overwrite then re-init; init_i, writes and reads during busy are ignored
        wr_valid = 1; wr_class = 2'd0; wr_addr = 6'd0; wr_data = 8'd9;
        tick();
        wr_valid = 0;
        do_read(2'd0, 6'd0, 9, "overwrite 9");
        init = 1;
        tick();
        check("init busy", int'(busy), 1);
        check("init wr_ready", int'(wr_ready), 0);
        wr_valid = 1; wr_data = 8'd9; rd_req = 1;
        count_busy(n, vseen);
        init = 0; wr_valid = 0; rd_req = 0;
        check("reinit cycles", n, 256);
        check("reads during reinit", vseen, 0);
        do_read(2'd0, 6'd0, 2, "reinit addr0");

        // reset in the middle of init
        do_read(2'd1, 6'd40, 2, "pre-reset read");
        init = 1;
        tick();
        init = 0;
        repeat (100) tick();
        check("init hold rd_data", int'($signed(rd_data)), 2);
        check("init rd_valid", int'(rd_valid), 0);
        #2 reset_i = 1'b1;
        #1;
        check("async busy", int'(busy), 1);
        check("async wr_ready", int'(wr_ready), 0);
        check("async rd_valid", int'(rd_valid), 0);
        check("async rd_data", int'(rd_data), 0);
        check("async rd_err", int'(rd_err), 0);
        tick();
        reset_i = 1'b0;
        count_busy(n, vseen);
        check("post-reset init cycles", n, 256);

        // back-to-back reads of class 2
        rd_req = 1; rd_class = 2'd2;
        for (int i = 0; i < 64; i++) begin
            rd_addr = 6'(i);
            tick();
            check($sformatf("burst[%0d] valid", i), int'(rd_valid), 1);
            check($sformatf("burst[%0d] data", i), int'($signed(rd_data)),
                  ((i % 8) < 4) ? 2 : -2);
        end
        rd_req = 0;
        tick();
        check("burst end valid", int'(rd_valid), 0);

        // 5-class instance
        n = 0;
        while (busy5 && n < 2000) begin
            tick();
            n++;
        end
        check("dut5 ready", int'(busy5), 0);
        wr_valid5 = 1; wr_class5 = 3'd7; wr_addr5 = 6'd0; wr_data5 = 8'd5;
        check("dut5 wr_ready", int'(wr_ready5), 1);
        tick();
        wr_valid5 = 0;
        rd_req5 = 1; rd_class5 = 3'd3; rd_addr5 = 6'd0;
        tick();
        check("dut5 c3 data", int'($signed(rd_data5)), -2);
        rd_class5 = 3'd7;
        tick();
        check("dut5 c7 valid", int'(rd_valid5), 1);
        check("dut5 c7 data", int'($signed(rd_data5)), 0);
        check("dut5 c7 err", int'(rd_err5), 1);
        rd_class5 = 3'd0;
        tick();
        check("dut5 c0 data", int'($signed(rd_data5)), 2);
        check("dut5 c0 err", int'(rd_err5), 0);
        rd_class5 = 3'd4; rd_addr5 = 6'd33;
        tick();
        check("dut5 c4 data", int'($signed(rd_data5)), 0);
        check("dut5 c4 err", int'(rd_err5), 0);
        rd_req5 = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/matmul_weight_bank.md
MATMUL_WEIGHT_BANK -- requirements
Module: matmul_weight_bank

Interface
REQ-001 SHALL have parameter WIDTH_P, default 8, image columns (power of 2, >=2).
REQ-002 SHALL have parameter HEIGHT_P, default 8, image rows (power of 2, >=2).
REQ-003 SHALL have parameter NUM_CLASSES_P, default 4, number of weight classes (>=1).
REQ-004 SHALL have parameter WEIGHT_WIDTH_P, default 8, signed weight width.
REQ-005 SHALL have parameter DEFAULT_MAG_P, default 2, magnitude of the init pattern (must fit signed WEIGHT_WIDTH_P).
REQ-006 Derived values: PIX = WIDTH_P*HEIGHT_P; DEPTH = NUM_CLASSES_P*PIX; CW = max(1,$clog2(NUM_CLASSES_P)); AW = $clog2(PIX).
REQ-007 Ports (one clock; reset asynchronous, active-high):
  clk_i  in  1  clock
  reset_i  in  1  async active-high reset
  init_i  in  1  request reload of default pattern
  busy_o  out  1  init sequence in progress
  wr_valid_i  in  1  write request
  wr_ready_o  out  1  write accepted when valid&ready
  wr_class_i  in  CW  write class
  wr_addr_i  in  AW  write pixel address {y,x}, x in low log2(WIDTH_P) bits
  wr_data_i  in  WEIGHT_WIDTH_P  signed write data
  rd_valid_i  in  1  read request
  rd_class_i  in  CW  read class
  rd_addr_i  in  AW  read pixel address
  rd_valid_o  out  1  read data valid
  rd_data_o  out  WEIGHT_WIDTH_P  signed read data
  rd_err_o  out  1  read class out of range

Function
REQ-008 Storage SHALL be DEPTH entries of signed WEIGHT_WIDTH_P, entry index = class*PIX + pixel address.
REQ-009 FSM SHALL have two states, INIT and READY.
REQ-010 In INIT, one entry per cycle SHALL be written with the default pattern, counter 0..DEPTH-1; after writing DEPTH-1 the next state SHALL be READY.
REQ-011 Default pattern (y = row, x = column of entry): class 0 +M if y<HEIGHT_P/2 else -M; class 1 +M if y>=HEIGHT_P/2 else -M; class 2 +M if x<WIDTH_P/2 else -M; class 3 +M if x>=WIDTH_P/2 else -M; classes >=4 SHALL be 0; M = DEFAULT_MAG_P.
REQ-012 busy_o SHALL equal (state==INIT); wr_ready_o SHALL equal (state==READY).
REQ-013 In INIT, wr_valid_i and rd_valid_i SHALL be ignored; rd_valid_o SHALL be 0.
REQ-014 init_i sampled high in READY SHALL move to INIT with counter 0 next cycle; any write or read in that same cycle SHALL still be performed; init_i in INIT SHALL be ignored.
REQ-015 A write SHALL occur on the clock edge where wr_valid_i & wr_ready_o; writes with wr_class_i >= NUM_CLASSES_P SHALL be dropped silently (handshake still completes).
REQ-016 Read latency SHALL be exactly 1 cycle: rd_valid_i high in READY at edge N gives rd_valid_o=1 and data after edge N; rd_valid_o SHALL be 0 in cycles without an accepted read.
REQ-017 rd_data_o SHALL hold its last value when rd_valid_o=0.
REQ-018 Read with rd_class_i >= NUM_CLASSES_P SHALL give rd_valid_o=1, rd_data_o=0, rd_err_o=1; otherwise rd_err_o=0.
REQ-019 Simultaneous read and write to the same entry SHALL return the old (pre-write) value.
REQ-020 Reads issue every cycle with no back-pressure; throughput one read and one write per cycle.
REQ-021 Init duration SHALL be exactly DEPTH cycles (256 with defaults).

Reset
REQ-022 reset_i high SHALL immediately force state INIT, counter 0, busy_o=1, wr_ready_o=0, rd_valid_o=0, rd_data_o=0, rd_err_o=0.
REQ-023 Storage contents SHALL not be reset directly; they SHALL be rewritten by the INIT sequence after reset release.
REQ-024 Reset asserted mid-INIT or mid-traffic SHALL restart the init sequence from entry 0.

Verification
REQ-025 Reset release, defaults -> busy_o=1 for 256 cycles then 0; read class0 addr 0 -> +2; class0 addr 63 -> -2; class3 addr 7 -> +2; class2 addr 7 -> -2.
REQ-026 Write class1 addr 10 data -5, next cycle read it -> rd_data_o=-5 one cycle after request; same-cycle read+write data 7 to addr 10 -> old -5, following read -> 7.
REQ-027 NUM_CLASSES_P=5: write class 7 -> dropped, wr_ready_o=1; read class 7 -> rd_valid_o=1, rd_data_o=0, rd_err_o=1; class 4 default reads 0.
REQ-028 Overwrite class0 addr 0 with 9, pulse init_i -> busy_o=1 for 256 cycles, reads suppressed, then addr 0 reads +2.
REQ-029 Assert reset_i at init count 100 -> outputs reset immediately; after release busy_o high a full 256 cycles.
REQ-030 Back-to-back reads of addr 0..63 class 2 every cycle -> 64 consecutive rd_valid_o pulses, data +2 for x<4, -2 for x>=4.
